// File: rtl/hpdcache_ram_1rw_init.sv
// Single-port (1RW) SRAM behavioural model with a configurable read latency,
// a coarse-grain write mask, a read-valid strobe and a post-reset fill
// sequencer. The array accepts no requests until every word holds INIT_VALUE.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | writing INIT_VALUE to word cnt_q each cycle, ready_o = 0
//   ST_RUN  | fill complete, ready_o = 1, requests accepted on cs_i
module hpdcache_ram_1rw_init #(
    parameter int ADDR_SIZE  = 6,
    parameter int DATA_SIZE  = 64,
    parameter int DEPTH      = 2**ADDR_SIZE,
    parameter int WMASK_GRAN = 8,
    parameter int RD_LATENCY = 1,
    parameter logic [DATA_SIZE-1:0] INIT_VALUE = '0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cs_i,
    input  logic                            we_i,
    input  logic [ADDR_SIZE-1:0]            addr_i,
    input  logic [DATA_SIZE-1:0]            wdata_i,
    input  logic [DATA_SIZE/WMASK_GRAN-1:0] wmask_i,
    output logic [DATA_SIZE-1:0]            rdata_o,
    output logic                            rvalid_o,
    output logic                            ready_o
);

    localparam int MASK_W = DATA_SIZE / WMASK_GRAN;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_SIZE:0]   DEPTH_A  = (ADDR_SIZE + 1)'(DEPTH);

    // Elaboration-time guards against configurations the model cannot honour.
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $fatal(1, "hpdcache_ram_1rw_init: RD_LATENCY must be in 1..4");
    end
    if ((DATA_SIZE % WMASK_GRAN) != 0) begin : g_bad_gran
        $fatal(1, "hpdcache_ram_1rw_init: DATA_SIZE must be a multiple of WMASK_GRAN");
    end
    if (DEPTH < 1 || DEPTH > 2**ADDR_SIZE) begin : g_bad_depth
        $fatal(1, "hpdcache_ram_1rw_init: DEPTH must be in 1..2**ADDR_SIZE");
    end

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   init_we;

    logic [DATA_SIZE-1:0]   mem_q [DEPTH];

    logic                   in_range;
    logic                   req_acc;
    logic                   rd_acc;
    logic                   mem_we;
    logic [ADDR_SIZE-1:0]   wr_idx;
    logic [DATA_SIZE-1:0]   wr_data;
    logic [DATA_SIZE-1:0]   wr_bm;
    logic [DATA_SIZE-1:0]   run_bm;
    logic [DATA_SIZE-1:0]   rd_data;

    logic                   vld_q [RD_LATENCY];
    logic [DATA_SIZE-1:0]   dat_q [RD_LATENCY];

    assign ready_o  = (state_q == ST_RUN);
    assign in_range = ({1'b0, addr_i} < DEPTH_A);
    assign req_acc  = cs_i & ready_o & ~rst_i;
    assign rd_acc   = req_acc & ~we_i;

    // Fill sequencer: walk cnt over every word once, then hand over to RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and fill counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Expand the coarse write mask to one enable per data bit.
    always_comb begin
        run_bm = '0;
        for (int i = 0; i < MASK_W; i++) begin
            run_bm[i*WMASK_GRAN +: WMASK_GRAN] = {WMASK_GRAN{wmask_i[i]}};
        end
    end

    // Single write port shared by the fill sequencer and user writes;
    // out-of-range user writes are dropped here.
    always_comb begin
        mem_we  = ~rst_i & (init_we | (req_acc & we_i & in_range));
        wr_idx  = init_we ? ADDR_SIZE'(cnt_q) : addr_i;
        wr_data = init_we ? INIT_VALUE : wdata_i;
        wr_bm   = init_we ? {DATA_SIZE{1'b1}} : run_bm;
    end

    // Array update; contents are not reset, the fill pass overwrites them.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_idx] <= (mem_q[wr_idx] & ~wr_bm) | (wr_data & wr_bm);
        end
    end

    // Read port: out-of-range reads return zero but still complete.
    always_comb begin
        rd_data = '0;
        if (in_range) begin
            rd_data = mem_q[addr_i];
        end
    end

    // Read pipeline: data only advances alongside a valid, so the last
    // stage holds the most recent read result between reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                dat_q[0] <= rd_data;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign rvalid_o = vld_q[RD_LATENCY-1];
    assign rdata_o  = dat_q[RD_LATENCY-1];

endmodule

// File: tb/tb_hpdcache_ram_1rw_init.sv
// Directed bench: four 16-word instances (read latency 1..4, fill A5A5...)
// and one 12-word instance (latency 1, fill 0) all driven by the same inputs.
module tb_hpdcache_ram_1rw_init;

    localparam logic [63:0] A  = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] W  = 64'h1122_3344_5566_7788;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        we;
    logic [3:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;

    logic [3:0]       rv16, rdy16;
    logic [3:0][63:0] rd16;
    logic             rv12, rdy12;
    logic [63:0]      rd12;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_lat
        hpdcache_ram_1rw_init #(
            .ADDR_SIZE(4), .DATA_SIZE(64), .DEPTH(16), .WMASK_GRAN(8),
            .RD_LATENCY(k + 1), .INIT_VALUE(A)
        ) u_dut (
            .clk_i(clk), .rst_i(rst), .cs_i(cs), .we_i(we), .addr_i(addr),
            .wdata_i(wdata), .wmask_i(wmask),
            .rdata_o(rd16[k]), .rvalid_o(rv16[k]), .ready_o(rdy16[k])
        );
    end

    hpdcache_ram_1rw_init #(
        .ADDR_SIZE(4), .DATA_SIZE(64), .DEPTH(12), .WMASK_GRAN(8),
        .RD_LATENCY(1), .INIT_VALUE(64'h0)
    ) u_dut12 (
        .clk_i(clk), .rst_i(rst), .cs_i(cs), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .wmask_i(wmask),
        .rdata_o(rd12), .rvalid_o(rv12), .ready_o(rdy12)
    );

    typedef struct {
        logic        cs;
        logic        we;
        logic [3:0]  addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic        exp_rv;
        logic [63:0] exp_rd16;
        logic [63:0] exp_rd12;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic w, input logic [3:0] a,
                         input logic [63:0] d, input logic [7:0] m);
        cs = c; we = w; addr = a; wdata = d; wmask = m;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic        any_rv;
        logic        any_rdy;
        int          lat;
        logic        ev;
        logic [63:0] ed;

        vecs[0]  = '{1'b1, 1'b0, 4'd0,  64'h0, 8'h00, 1'b1, A, 64'h0};
        vecs[1]  = '{1'b1, 1'b0, 4'd15, 64'h0, 8'h00, 1'b1, A, 64'h0};
        vecs[2]  = '{1'b1, 1'b1, 4'd3,  W,     8'h0F, 1'b0, A, 64'h0};
        vecs[3]  = '{1'b1, 1'b0, 4'd3,  64'h0, 8'h00, 1'b1,
                     64'hA5A5_A5A5_5566_7788, 64'h0000_0000_5566_7788};
        vecs[4]  = '{1'b1, 1'b1, 4'd3,  W,     8'h00, 1'b0,
                     64'hA5A5_A5A5_5566_7788, 64'h0000_0000_5566_7788};
        vecs[5]  = '{1'b1, 1'b0, 4'd3,  64'h0, 8'h00, 1'b1,
                     64'hA5A5_A5A5_5566_7788, 64'h0000_0000_5566_7788};
        vecs[6]  = '{1'b1, 1'b1, 4'd5,  64'hDEAD, 8'hFF, 1'b0,
                     64'hA5A5_A5A5_5566_7788, 64'h0000_0000_5566_7788};
        vecs[7]  = '{1'b1, 1'b0, 4'd5,  64'h0, 8'h00, 1'b1, 64'hDEAD, 64'hDEAD};
        vecs[8]  = '{1'b1, 1'b1, 4'd13, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0,
                     64'hDEAD, 64'hDEAD};
        vecs[9]  = '{1'b1, 1'b0, 4'd13, 64'h0, 8'h00, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0};
        vecs[10] = '{1'b0, 1'b0, 4'd0,  64'h0, 8'h00, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0};
        vecs[11] = '{1'b1, 1'b1, 4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 1'b0,
                     64'h0123_4567_89AB_CDEF, 64'h0};
        vecs[12] = '{1'b1, 1'b0, 4'd0,  64'h0, 8'h00, 1'b1,
                     64'hFFFF_FFFF_A5A5_A5A5, 64'hFFFF_FFFF_0000_0000};
        vecs[13] = '{1'b1, 1'b0, 4'd11, 64'h0, 8'h00, 1'b1, A, 64'h0};

        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 64'h0, 8'h00);
        repeat (3) tick();

        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset ready L%0d", k + 1), 64'(rdy16[k]), 64'h0);
            check($sformatf("reset rvalid L%0d", k + 1), 64'(rv16[k]), 64'h0);
            check($sformatf("reset rdata L%0d", k + 1), rd16[k], 64'h0);
        end
        check("reset ready d12", 64'(rdy12), 64'h0);

        // Fill: cs read pulses while not ready must be ignored.
        rst = 1'b0;
        any_rv = 1'b0;
        for (int c = 0; c < 16; c++) begin
            drive(c <= 10, 1'b0, 4'(c), 64'h0, 8'h00);
            tick();
            any_rv |= (|rv16) | rv12;
            if (c == 10) check("d12 ready low at E10", 64'(rdy12), 64'h0);
            if (c == 11) check("d12 ready high at E11", 64'(rdy12), 64'h1);
            if (c == 14) check("ready low at E14", 64'(rdy16), 64'h0);
            if (c == 15) check("ready high at E15", 64'(rdy16), 64'hF);
        end
        drive(1'b0, 1'b0, 4'd0, 64'h0, 8'h00);
        repeat (4) tick();
        any_rv |= (|rv16) | rv12;
        check("no rvalid during init", 64'(any_rv), 64'h0);

        // Every word reads back the fill value.
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1'b0, 4'(a), 64'h0, 8'h00);
            tick();
            check($sformatf("init read a%0d", a), {rv16[0], rd16[0]}, {1'b1, A});
            check($sformatf("init read d12 a%0d", a), {rv12, rd12}, {1'b1, 64'h0});
        end

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].cs, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
            tick();
            check($sformatf("vec%0d rvalid", i), 64'(rv16[0]), 64'(vecs[i].exp_rv));
            check($sformatf("vec%0d rdata", i), rd16[0], vecs[i].exp_rd16);
            check($sformatf("vec%0d d12 rvalid", i), 64'(rv12), 64'(vecs[i].exp_rv));
            check($sformatf("vec%0d d12 rdata", i), rd12, vecs[i].exp_rd12);
        end

        // Out-of-range write must not have touched any in-range word.
        for (int a = 0; a < 12; a++) begin
            case (a)
                0:       ed = 64'hFFFF_FFFF_0000_0000;
                3:       ed = 64'h0000_0000_5566_7788;
                5:       ed = 64'hDEAD;
                default: ed = 64'h0;
            endcase
            drive(1'b1, 1'b0, 4'(a), 64'h0, 8'h00);
            tick();
            check($sformatf("d12 word%0d", a), rd12, ed);
        end
        drive(1'b0, 1'b0, 4'd0, 64'h0, 8'h00);
        repeat (4) tick();

        // Latency sweep: preload 0..3, then four back-to-back reads.
        for (int a = 0; a < 4; a++) begin
            drive(1'b1, 1'b1, 4'(a), 64'(a), 8'hFF);
            tick();
        end
        drive(1'b0, 1'b0, 4'd0, 64'h0, 8'h00);
        tick();
        for (int j = 0; j < 9; j++) begin
            if (j < 4) drive(1'b1, 1'b0, 4'(j), 64'h0, 8'h00);
            else       drive(1'b0, 1'b0, 4'd0, 64'h0, 8'h00);
            tick();
            for (int k = 0; k < 4; k++) begin
                lat = k + 1;
                ev  = (j >= lat - 1) && (j <= lat + 2);
                if (j < lat - 1)       ed = A;
                else if (j <= lat + 2) ed = 64'(j - (lat - 1));
                else                   ed = 64'd3;
                check($sformatf("sweep L%0d j%0d rvalid", lat, j), 64'(rv16[k]), 64'(ev));
                check($sformatf("sweep L%0d j%0d rdata", lat, j), rd16[k], ed);
            end
        end

        // Reset one cycle after a read accept on the latency-3 instance.
        drive(1'b1, 1'b0, 4'd1, 64'h0, 8'h00);
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b0, 4'd2, 64'h0, 8'h00);
        tick();
        check("midrst rvalid", 64'(rv16[2]), 64'h0);
        check("midrst ready", 64'(rdy16[2]), 64'h0);
        check("midrst rdata", rd16[2], 64'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 64'h0, 8'h00);
        any_rv  = 1'b0;
        any_rdy = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            any_rv |= rv16[2];
            if (c < 15) any_rdy |= rdy16[2];
        end
        check("midrst no rvalid", 64'(any_rv), 64'h0);
        check("midrst ready low during refill", 64'(any_rdy), 64'h0);
        check("midrst ready after refill", 64'(rdy16[2]), 64'h1);

        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1'b0, 4'(a), 64'h0, 8'h00);
            tick();
            drive(1'b0, 1'b0, 4'd0, 64'h0, 8'h00);
            repeat (2) tick();
            check($sformatf("refill L3 a%0d", a), {rv16[2], rd16[2]}, {1'b1, A});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hpdcache_ram_1rw_init.md
# hpdcache_ram_1rw_init

Parametrised single-port (1RW) SRAM behavioural model with configurable read latency, coarse-grain write mask, a read-valid strobe and a hardware initialisation sequencer that fills the array with a constant after reset. It replaces the plain 1RW model in the HPDcache data and directory arrays wherever the cache needs deterministic post-reset contents or a multi-cycle macro latency. Requests are accepted only once initialisation is complete, as signalled by `ready`.

## Interface
- `ADDR_SIZE`, 6: address width.
- `DATA_SIZE`, 64: word width in bits.
- `DEPTH`, 2**ADDR_SIZE: number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_SIZE.
- `WMASK_GRAN`, 8: bits covered by one mask bit; DATA_SIZE % WMASK_GRAN must be 0.
- `RD_LATENCY`, 1: cycles from accepted read to `rvalid`; legal range 1..4.
- `INIT_VALUE`, '0: DATA_SIZE-bit value written to every word during initialisation.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cs`  in  1  request strobe.
- `we`  in  1  1 = write, 0 = read.
- `addr`  in  ADDR_SIZE  word address.
- `wdata`  in  DATA_SIZE  write data.
- `wmask`  in  DATA_SIZE/WMASK_GRAN  mask bit i enables bits [i*WMASK_GRAN +: WMASK_GRAN].
- `rdata`  out  DATA_SIZE  read data; held until the next read completes.
- `rvalid`  out  1  one-cycle pulse marking new `rdata`.
- `ready`  out  1  initialisation done; requests are accepted only while high.

## Operation
- **Reset values:** `ready`=0, `rvalid`=0, `rdata`=0, init counter=0, FSM=INIT, read pipeline cleared.
  - Array contents are not reset directly; the INIT pass overwrites them.
- **FSM INIT:** each cycle with `rst` low, writes INIT_VALUE to word `cnt` (full mask), then increments `cnt`.
  - After writing word DEPTH-1, moves to RUN and sets `ready`=1.
  - `cnt` is $clog2(DEPTH)+1 bits wide, so there is no wrap.
- **FSM RUN:** a request is accepted when `cs & ready`.
  - While `ready`=0, `cs` is ignored: no array access, no `rvalid`.
- **Write** (`cs & we`): `mem[addr] <= (mem[addr] & ~M) | (wdata & M)`.
  - M is `wmask` with each bit replicated WMASK_GRAN times.
  - `wmask`=0 leaves the word unchanged.
  - No `rvalid` is generated.
- **Read** (`cs & ~we`): the array is sampled at the accept edge.
  - The data travels through a RD_LATENCY-1 stage valid/data shift pipeline.
  - When it reaches the output, `rdata` is loaded and `rvalid` pulses.
  - `rdata` is unchanged at all other times.
- **Out of range** (`addr ≥ DEPTH`):
  - Writes are dropped.
  - Reads complete normally with `rdata`=0 and `rvalid` pulsed.
- **Back-to-back:** one request per cycle, fully pipelined. Reads issued on consecutive cycles produce `rvalid` on consecutive cycles, in order.
- **Write then read, same address, next cycle:** the read returns the newly written data.
- **Reset mid-operation:**
  - Reset asserted during INIT or RUN returns the FSM to INIT with `cnt`=0.
  - `ready`, `rvalid` and `rdata` drop to 0 on the next edge.
  - In-flight reads are discarded.
  - A request presented in the reset cycle is ignored.
- **Parameter checks:** illegal parameters (RD_LATENCY outside 1..4, non-divisible WMASK_GRAN, DEPTH > 2**ADDR_SIZE) trigger a simulation-time `$fatal`.

## Timing
- **Initialisation:** E0 is the first rising edge with `rst`=0.
  - Word k is written at edge E(k).
  - `ready` is high from just after E(DEPTH-1), so the first request can be accepted at edge E(DEPTH).
  - Initialisation therefore takes exactly DEPTH cycles.
- **Read latency:** a read accepted at edge T gives `rvalid`=1 and new `rdata` in the cycle after edge T+RD_LATENCY-1.
  - With RD_LATENCY=1, data appears in the cycle directly following the accept edge.
- **Write:** takes effect at the accept edge and is visible to a read accepted at the next edge.
- **Handshake:** there is no backpressure. `rvalid` is a pulse, and the consumer must capture `rdata` or rely on its hold property.

## Test plan
- **Init fill:** DEPTH=16, INIT_VALUE=64'hA5A5_A5A5_A5A5_A5A5. Release reset.
  - `ready` rises exactly 16 cycles later.
  - Reading addresses 0..15 returns A5A5… on every read.
  - `cs` pulses issued during init produce no `rvalid`.
- **Masked write:** write 64'h1122_3344_5566_7788 with `wmask`=8'h0F at addr 3 (init value 0), then read.
  - Returns 64'h0000_0000_5566_7788.
  - With `wmask`=8'h00 the word stays unchanged.
- **Latency sweep:** for RD_LATENCY 1, 2, 3, 4, issue four back-to-back reads of addrs 0..3 preloaded with 0..3.
  - `rvalid` is high for 4 consecutive cycles, starting RD_LATENCY cycles after the first accept edge.
  - Data arrives in order 0, 1, 2, 3.
  - `rdata` holds 3 afterwards.
- **Write-read forwarding:** write 64'hDEAD at addr 5 at edge T, read addr 5 at edge T+1.
  - Returns 64'hDEAD.
- **Out of range:** DEPTH=12, ADDR_SIZE=4. Write addr 13, then read addr 13.
  - Read gives `rdata`=0 with `rvalid`=1.
  - Words 0..11 are unaffected.
- **Reset mid-operation:** RD_LATENCY=3. Assert `rst` for 1 cycle one cycle after a read accept.
  - No `rvalid` appears.
  - `ready` stays 0 for the next DEPTH cycles.
  - The array is refilled with INIT_VALUE.
